sep_fifo_sched: RTL and testbench
=================================

// Module: sep_fifo_sched
// PURPOSE
//  Scheduler in front of the data_separator -> fifo byte path. Round-robin arbitrates
//  NREQ 32-bit word requesters onto the separator's single data_i/valid_pulse_i port.
//  Tracks FIFO occupancy and only launches a word when the FIFO has room for all its bytes.
//  Drains the FIFO to a downstream consumer via rd_en under a ready handshake.
// PARAMETERS
//  NREQ        2    number of word requesters (>=2)
//  BPW         4    bytes emitted by separator per word (valid_o pulses per valid_pulse_i)
//  FIFO_DEPTH  16   byte capacity of the downstream fifo
//  CW          $clog2(FIFO_DEPTH+1)  occupancy counter width
// PORTS
//  clk                 in   1        clock, all logic on rising edge
//  rstn                in   1        synchronous reset, active-high (1 = reset)
//  req_valid_i         in   NREQ     requester i has a word pending
//  req_data_i          in   32*NREQ  word of requester i at [32*i +: 32]
//  req_ready_o         out  NREQ     one-hot pulse: word of requester i accepted this cycle
//  sep_data_o          out  32       to separator data_i (held stable from launch to word end)
//  sep_valid_pulse_o   out  1        to separator valid_pulse_i, exactly 1 cycle per word
//  sep_valid_i         in   1        separator valid_o (= fifo wr_en), one per byte written
//  fifo_rd_en_o        out  1        fifo rd_en
//  out_ready_i         in   1        consumer can take a byte
//  out_valid_o         out  1        fifo data_out valid (rd_en delayed 1 cycle)
//  occ_o               out  CW       current fifo byte occupancy
//  busy_o              out  1        word in flight (state != IDLE)
//  err_o               out  1        sticky protocol error
// BEHAVIOUR
//  Reset (rstn=1 at edge): state=IDLE, occ=0, rr_ptr=0, byte_cnt=0; outputs req_ready_o=0,
//   sep_data_o=0, sep_valid_pulse_o=0, out_valid_o=0, err_o=0. Reset mid-word aborts the word;
//   separator and fifo share this reset, so no stale bytes are counted afterward.
//  FSM: IDLE -> LAUNCH -> WAIT -> IDLE.
//   IDLE: if any req_valid_i and occ+BPW <= FIFO_DEPTH: grant = first valid index searching
//    rr_ptr, rr_ptr+1, ... mod NREQ; pulse req_ready_o[grant]; latch word into sep_data_o;
//    rr_ptr <= (grant+1) mod NREQ; byte_cnt <= 0; go LAUNCH. Otherwise stay, no grant.
//   LAUNCH: sep_valid_pulse_o=1 for this cycle only; go WAIT.
//   WAIT: byte_cnt increments on each sep_valid_i; on the BPW-th byte go IDLE.
//    Next grant earliest the cycle after returning to IDLE (min 2+BPW cycles per word).
//  Requester must hold req_valid_i/data until its req_ready_o pulse; dropping earlier is legal
//   (request withdrawn, not granted).
//  Occupancy: occ <= occ + sep_valid_i - fifo_rd_en_o; simultaneous write and read -> unchanged.
//   Space check in IDLE uses registered occ; concurrent reads only add margin, never overflow.
//  Drain: fifo_rd_en_o = out_ready_i & (occ != 0), combinational from registered occ.
//   out_valid_o <= fifo_rd_en_o (fifo read latency 1 cycle).
//  err_o set (sticky until reset) on: sep_valid_i while state != WAIT; occ at FIFO_DEPTH with
//   sep_valid_i and no read (overflow). Error does not stall the FSM; occ saturates at FIFO_DEPTH.
//  busy_o = (state != IDLE). occ_o = occ.
// TESTING
//  1 Single word: req0 valid, data 32'h1234, out_ready_i=0 -> req_ready_o=01 at T, pulse at T+1,
//    4 sep_valid_i bytes, occ_o ends 4, busy_o low after 4th byte, err_o=0.
//  2 Round-robin: both requesters hold valid (h5678, h9abc) for 4 words -> grants 0,1,0,1;
//    sep_data_o matches granted word each launch.
//  3 Backpressure: out_ready_i=0, req0 always valid -> exactly 4 words accepted (occ_o=16),
//    no 5th grant; raise out_ready_i for 4 cycles -> occ_o=12, 5th word then granted.
//  4 Simultaneous write/read: out_ready_i=1 during byte stream -> occ_o stays constant on those
//    cycles; out_valid_o follows fifo_rd_en_o by exactly 1 cycle.
//  5 Protocol error: inject sep_valid_i in IDLE -> err_o=1 next cycle, stays 1 until rstn.
//  6 Reset mid-word: assert rstn during WAIT after 2 bytes -> next cycle state IDLE, occ_o=0,
//    rr_ptr=0, no outputs asserted; a new word afterward completes normally.

Source files
------------

// File: rtl/sep_fifo_sched_if.sv
// sep_fifo_sched_if: requester word bus shared by NREQ requesters and the scheduler
interface sep_fifo_sched_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]    valid;
  logic [32*NREQ-1:0] data;
  logic [NREQ-1:0]    ready;
  modport master (output valid, data, input ready);
  modport slave  (input valid, data, output ready);
endinterface

// File: rtl/sep_fifo_sched.sv
// sep_fifo_sched: round-robin word scheduler feeding separator->fifo with occupancy tracking and drain
module sep_fifo_sched #(
  parameter int NREQ       = 2,
  parameter int BPW        = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  sep_fifo_sched_if.slave  req,
  output logic [31:0]      sep_data_o,
  output logic             sep_valid_pulse_o,
  input  logic             sep_valid_i,
  output logic             fifo_rd_en_o,
  input  logic             out_ready_i,
  output logic             out_valid_o,
  output logic [CW-1:0]    occ_o,
  output logic             busy_o,
  output logic             err_o
);
  localparam int PW = $clog2(NREQ);
  localparam int BW = $clog2(BPW + 1);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_e;
  state_e          state_q, state_d;
  logic [PW-1:0]   rr_q, rr_d;
  logic [BW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   occ_q, occ_d;
  logic [31:0]     data_q, data_d;
  logic            pulse_q, pulse_d;
  logic            outv_q, outv_d;
  logic            err_q, err_d;
  logic [2*NREQ-1:0] vv;
  logic [PW-1:0]   gnt;
  logic            found, grant, ovf;
  int              s;
  // round-robin search starting at rr_q over a doubled valid vector
  always_comb begin
    vv = {req.valid, req.valid} >> rr_q;
    found = 1'b0;
    gnt = '0;
    s = 0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && |(vv & ((2*NREQ)'(1) << k))) begin
        found = 1'b1;
        s = int'(rr_q) + k;
        gnt = PW'(s >= NREQ ? s - NREQ : s);
      end
    end
    grant = (state_q == IDLE) && found && (occ_q <= CW'(FIFO_DEPTH - BPW));
    req.ready = grant ? NREQ'(1) << gnt : '0;
  end
  assign fifo_rd_en_o      = out_ready_i && (occ_q != '0);
  assign ovf               = sep_valid_i && !fifo_rd_en_o && (occ_q == CW'(FIFO_DEPTH));
  assign sep_data_o        = data_q;
  assign sep_valid_pulse_o = pulse_q;
  assign out_valid_o       = outv_q;
  assign occ_o             = occ_q;
  assign busy_o            = (state_q != IDLE);
  assign err_o             = err_q;
  // next-state: word FSM, byte counting, occupancy and sticky error
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    pulse_d = grant;
    if (grant) begin
      state_d = LAUNCH;
      rr_d    = (gnt == PW'(NREQ - 1)) ? '0 : gnt + 1'b1;
      cnt_d   = '0;
      data_d  = req.data[32*gnt +: 32];
    end else if (state_q == LAUNCH) begin
      state_d = WAIT;
    end else if (state_q == WAIT && sep_valid_i) begin
      cnt_d   = cnt_q + 1'b1;
      state_d = (cnt_q == BW'(BPW - 1)) ? IDLE : WAIT;
    end
    occ_d  = ovf ? occ_q : occ_q + CW'(sep_valid_i) - CW'(fifo_rd_en_o);
    err_d  = err_q || ovf || (sep_valid_i && state_q != WAIT);
    outv_d = fifo_rd_en_o;
  end
  // state registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q <= IDLE;
      rr_q    <= '0;
      cnt_q   <= '0;
      occ_q   <= '0;
      data_q  <= '0;
      pulse_q <= 1'b0;
      outv_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      occ_q   <= occ_d;
      data_q  <= data_d;
      pulse_q <= pulse_d;
      outv_q  <= outv_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_sep_fifo_sched.sv
// tb_sep_fifo_sched: directed plus random checks of sep_fifo_sched against a cycle reference model
module tb_sep_fifo_sched;
  localparam int NREQ = 2;
  localparam int BPW = 4;
  localparam int DEPTH = 16;
  localparam int CW = 5;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic [31:0] sep_data;
  logic pulse, sv, rd_en, ordy, ovalid, busy, err;
  logic [CW-1:0] occ;
  sep_fifo_sched_if #(.NREQ(NREQ)) rif ();
  sep_fifo_sched #(.NREQ(NREQ), .BPW(BPW), .FIFO_DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rstn(rstn), .req(rif),
    .sep_data_o(sep_data), .sep_valid_pulse_o(pulse), .sep_valid_i(sv),
    .fifo_rd_en_o(rd_en), .out_ready_i(ordy), .out_valid_o(ovalid),
    .occ_o(occ), .busy_o(busy), .err_o(err)
  );
  always #5 clk = ~clk;
  int total = 0;
  int bad = 0;
  int m_occ, m_rr, m_left, last_g;
  bit m_launch, m_err, m_outv;
  logic [31:0] m_data;
  bit auto_sep;
  int grants[$];
  int gcount;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic expire(input string tag);
    total++;
    bad++;
    $error("FAIL %s got=timeout exp=event", tag);
  endtask
  task automatic cyc();
    bit idle, rdx, wait_st;
    int g, idx;
    logic [NREQ-1:0] er;
    if (auto_sep) sv = (m_left > 0 && !m_launch) ? ($urandom_range(3) != 0) : 1'b0;
    @(negedge clk);
    idle = !m_launch && m_left == 0;
    rdx = ordy && m_occ > 0;
    g = -1;
    if (idle && m_occ + BPW <= DEPTH)
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_rr + k) % NREQ;
        if (g < 0 && ((rif.valid >> idx) & 1) != 0) g = idx;
      end
    er = (g < 0) ? '0 : NREQ'(1) << g;
    chk("ready", 32'(rif.ready), 32'(er));
    chk("pulse", 32'(pulse), 32'(m_launch));
    chk("sep_data", sep_data, m_data);
    chk("rd_en", 32'(rd_en), 32'(rdx));
    chk("out_valid", 32'(ovalid), 32'(m_outv));
    chk("occ", 32'(occ), m_occ);
    chk("busy", 32'(busy), 32'(!idle));
    chk("err", 32'(err), 32'(m_err));
    if (rstn) begin
      m_occ = 0; m_rr = 0; m_left = 0; m_launch = 0; m_err = 0; m_outv = 0; m_data = 0; last_g = -1;
    end else begin
      wait_st = !m_launch && m_left > 0;
      if (sv && !wait_st) m_err = 1;
      if (sv && !rdx && m_occ == DEPTH) m_err = 1;
      else m_occ = m_occ + int'(sv) - int'(rdx);
      m_outv = rdx;
      if (wait_st && sv) m_left--;
      if (m_launch) begin m_launch = 0; m_left = BPW; end
      if (g >= 0) begin
        m_launch = 1;
        m_data = rif.data[32*g +: 32];
        m_rr = (g + 1) % NREQ;
        grants.push_back(g);
        gcount++;
      end
      last_g = g;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rstn = 1'b1; sv = 1'b0; rif.valid = '0; ordy = 1'b0;
    cyc(); cyc();
    rstn = 1'b0;
    grants.delete();
    gcount = 0;
  endtask
  task automatic wait_grant(input int max, output int gg);
    int n = 0;
    gg = -1;
    while (gg < 0 && n < max) begin cyc(); gg = last_g; n++; end
    if (gg < 0) expire("wait_grant");
  endtask
  task automatic wait_idle(input int max);
    int n = 0;
    while ((m_launch || m_left > 0) && n < max) begin cyc(); n++; end
    if (m_launch || m_left > 0) expire("wait_idle");
  endtask
  initial begin
    int gg, n;
    bit prev_rd;
    rif.valid = '0; rif.data = '0; sv = 0; ordy = 0; auto_sep = 1;
    m_occ = 0; m_rr = 0; m_left = 0; m_launch = 0; m_err = 0; m_outv = 0; m_data = 0; last_g = -1;
    do_reset();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_occ", 32'(occ), 0);
    // single word
    rif.data[31:0] = 32'h1234; rif.valid = 2'b01;
    wait_grant(10, gg);
    chk("t1_gnt", gg, 0);
    rif.valid = '0;
    chk("t1_pulse", 32'(pulse), 1);
    chk("t1_data", sep_data, 32'h1234);
    wait_idle(40);
    chk("t1_occ", 32'(occ), 4);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_err", 32'(err), 0);
    // round robin
    do_reset();
    ordy = 1'b1;
    rif.data = {32'h9abc, 32'h5678}; rif.valid = 2'b11;
    n = 0;
    while (gcount < 4 && n < 200) begin cyc(); n++; end
    rif.valid = '0;
    wait_idle(40);
    chk("t2_count", gcount, 4);
    for (int i = 0; i < 4 && i < grants.size(); i++) chk("t2_order", grants[i], i % 2);
    // backpressure
    do_reset();
    rif.data[31:0] = $urandom; rif.valid = 2'b01;
    for (int i = 0; i < 80; i++) cyc();
    chk("t3_count", gcount, 4);
    chk("t3_occ", 32'(occ), 16);
    ordy = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    ordy = 1'b0;
    chk("t3_occ12", 32'(occ), 12);
    wait_grant(5, gg);
    chk("t3_fifth", gcount, 5);
    rif.valid = '0;
    wait_idle(40);
    // simultaneous write/read
    do_reset();
    auto_sep = 0; ordy = 1'b1;
    rif.data[63:32] = 32'hcafe; rif.valid = 2'b10;
    wait_grant(10, gg);
    rif.valid = '0;
    cyc();
    prev_rd = 0;
    for (int i = 0; i < BPW; i++) begin
      sv = 1'b1;
      cyc();
      chk("t4_follow", 32'(ovalid), 32'(prev_rd));
      prev_rd = rd_en;
    end
    sv = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    auto_sep = 1;
    // protocol error
    do_reset();
    auto_sep = 0;
    sv = 1'b1; cyc(); sv = 1'b0;
    for (int i = 0; i < 4; i++) begin cyc(); chk("t5_sticky", 32'(err), 1); end
    do_reset();
    chk("t5_clear", 32'(err), 0);
    // reset mid-word
    rif.data[31:0] = 32'h1111; rif.valid = 2'b01;
    wait_grant(10, gg);
    rif.valid = '0;
    cyc();
    sv = 1'b1; cyc(); cyc(); sv = 1'b0;
    rstn = 1'b1; cyc(); rstn = 1'b0;
    chk("t6_busy", 32'(busy), 0);
    chk("t6_occ", 32'(occ), 0);
    chk("t6_pulse", 32'(pulse), 0);
    chk("t6_ovalid", 32'(ovalid), 0);
    auto_sep = 1;
    rif.data = {32'h2222, 32'h3333}; rif.valid = 2'b11;
    wait_grant(10, gg);
    chk("t6_rr0", gg, 0);
    rif.valid = '0;
    wait_idle(40);
    chk("t6_occ4", 32'(occ), 4);
    // random traffic
    do_reset();
    for (int c = 0; c < 400; c++) begin
      ordy = ($urandom_range(2) != 0);
      cyc();
      for (int i = 0; i < NREQ; i++) begin
        if (last_g == i || (((rif.valid >> i) & 1) != 0 && $urandom_range(9) == 0))
          rif.valid = rif.valid & ~(NREQ'(1) << i);
        else if (((rif.valid >> i) & 1) == 0 && $urandom_range(2) == 0) begin
          rif.valid = rif.valid | (NREQ'(1) << i);
          rif.data[32*i +: 32] = $urandom;
        end
      end
    end
    chk("rand_err", 32'(err), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
